// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction-stream producer and the encoder.
// The master drives requests and consumes words; the slave is the encoder.
interface instr_encoder_if;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] enc_cnt;

    modport master (
        output clear, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_code, enc_cnt
    );

    modport slave (
        input  clear, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_code, enc_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I subset encoder (lw/sw/beq/add/sub/and/or) feeding a small FIFO that emits
// words with contiguous instruction-memory addresses.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [31:0]   addr_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic [15:0]   enc_cnt_q;

    logic [31:0] word_d;
    logic [1:0]  code_d;
    logic        full, empty, accept, push, pop;

    logic [12:0] imm;
    logic [4:0]  rd, rs1, rs2;
    assign imm = bus.in_imm;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;

    // code_d of 0 means the request is legal and will be enqueued
    always_comb begin
        word_d = '0;
        code_d = 2'd0;
        case (bus.in_op)
            3'd0: begin
                word_d = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
                if (imm[12] != imm[11]) code_d = 2'd1;
            end
            3'd1: begin
                word_d = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                if (imm[12] != imm[11]) code_d = 2'd1;
            end
            3'd2: begin
                word_d = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
                if (imm[0]) code_d = 2'd2;
            end
            3'd3: word_d = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd4: word_d = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd5: word_d = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            3'd6: word_d = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            default: code_d = 2'd3;
        endcase
    end

    // in_ready looks only at occupancy, so a same-cycle pop never frees a slot
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid && !full && !bus.clear;
    assign push   = accept && (code_d == 2'd0);
    assign pop    = !empty && bus.out_ready && !bus.clear;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.enc_cnt   = enc_cnt_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            enc_cnt_q  <= '0;
        end else if (bus.clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            enc_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PW + 1)'(1);
            if (pop)  addr_q    <= addr_q + 32'd4;
            if (push) enc_cnt_q <= enc_cnt_q + 16'd1;
            err_q <= accept && (code_d != 2'd0);
            if (accept && (code_d != 2'd0)) err_code_q <= code_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle, directed
// literal expectations from hand-encoded RV32I words, then randomized traffic.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk;
    logic rst_n;
    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference encoding built arithmetically from field values
    function automatic logic [31:0] ref_word(input int op, input logic [31:0] rd,
                                             input logic [31:0] rs1, input logic [31:0] rs2,
                                             input int imm);
        logic [31:0] u;
        logic [31:0] f7, f3;
        u = imm;
        case (op)
            0: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
            2: return (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'd1) << 7) | 32'h63;
            default: begin
                f7 = (op == 4) ? 32'd32 : 32'd0;
                f3 = (op == 5) ? 32'd7 : (op == 6) ? 32'd6 : 32'd0;
                return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
        endcase
    endfunction

    function automatic int ref_code(input int op, input int imm);
        if (op == 7) return 3;
        if ((op == 0 || op == 1) && (imm < -2048 || imm > 2047)) return 1;
        if (op == 2 && (imm % 2) != 0) return 2;
        return 0;
    endfunction

    logic [31:0] mq[$];
    logic [31:0] m_addr = BASE;
    logic        m_err  = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [15:0] m_cnt  = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        int  code, simm;
        bit  acc, pop;
        if (!rst_n) begin
            mq.delete();
            m_addr = BASE;
            m_err  = 1'b0;
            m_code = 2'd0;
            m_cnt  = 16'd0;
        end else if (bus.clear) begin
            mq.delete();
            m_addr = BASE;
            m_err  = 1'b0;
            m_cnt  = 16'd0;
        end else begin
            acc  = bus.in_valid && (mq.size() < DEPTH);
            pop  = (mq.size() > 0) && bus.out_ready;
            simm = int'($signed(bus.in_imm));
            code = ref_code(int'(bus.in_op), simm);
            if (pop) begin
                void'(mq.pop_front());
                m_addr = m_addr + 32'd4;
            end
            m_err = 1'b0;
            if (acc) begin
                if (code == 0) begin
                    mq.push_back(ref_word(int'(bus.in_op), 32'(bus.in_rd), 32'(bus.in_rs1),
                                          32'(bus.in_rs2), simm));
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_err  = 1'b1;
                    m_code = 2'(code);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("out_instr", bus.out_instr, (mq.size() > 0) ? mq[0] : 32'h0);
        chk("out_addr",  bus.out_addr,  m_addr);
        chk("err",       32'(bus.err),      32'(m_err));
        chk("err_code",  32'(bus.err_code), 32'(m_code));
        chk("enc_cnt",   32'(bus.enc_cnt),  32'(m_cnt));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input int op, input int rd, input int rs1, input int rs2, input int imm);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'(op);
        bus.in_rd    = 5'(rd);
        bus.in_rs1   = 5'(rs1);
        bus.in_rs2   = 5'(rs2);
        bus.in_imm   = 13'(imm);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        req(3, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst out_addr",  bus.out_addr, 32'h0);
        chk("rst enc_cnt",   32'(bus.enc_cnt), 32'd0);
        chk("rst out_instr", bus.out_instr, 32'h0);

        bus.out_ready = 1'b1;
        req(0, 30, 1, 0, 8);
        tick();
        chk("lw word", bus.out_instr, 32'h0080af03);
        chk("lw addr", bus.out_addr, 32'h0);
        req(1, 0, 1, 2, -12);
        tick();
        chk("sw word", bus.out_instr, 32'hfe20aa23);
        chk("sw addr", bus.out_addr, 32'h4);
        idle();
        tick();
        chk("enc_cnt two", 32'(bus.enc_cnt), 32'd2);

        req(2, 0, 5, 11, -14);
        tick();
        chk("beq neg", bus.out_instr, 32'hfeb289e3);
        req(2, 0, 1, 2, 8);
        tick();
        chk("beq pos", bus.out_instr, 32'h00208463);
        req(4, 30, 1, 2, 0);
        tick();
        chk("sub", bus.out_instr, 32'h40208f33);
        req(6, 30, 1, 2, 0);
        tick();
        chk("or", bus.out_instr, 32'h0020ef33);
        req(3, 30, 1, 2, 0);
        tick();
        chk("add", bus.out_instr, 32'h00208f33);
        req(5, 30, 1, 2, 0);
        tick();
        chk("and", bus.out_instr, 32'h0020ff33);
        idle();
        tick();

        // backpressure
        bus.clear = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(3, i + 1, i, i + 2, 0);
            tick();
        end
        chk("bp full in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp full enc_cnt",  32'(bus.enc_cnt),  32'd4);
        req(3, 9, 9, 9, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp pop no push cnt", 32'(bus.enc_cnt), 32'd4);
        chk("bp pop addr",        bus.out_addr, 32'h4);
        bus.out_ready = 1'b0;
        tick();
        chk("bp next accept cnt", 32'(bus.enc_cnt), 32'd5);
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("bp drained valid", 32'(bus.out_valid), 32'd0);
        chk("bp drained addr",  bus.out_addr, 32'h14);

        // rejected requests
        req(0, 3, 3, 0, 2048);
        tick();
        chk("lw range err",  32'(bus.err), 32'd1);
        chk("lw range code", 32'(bus.err_code), 32'd1);
        chk("lw range no word", 32'(bus.out_valid), 32'd0);
        req(2, 0, 1, 2, 3);
        tick();
        chk("beq align code", 32'(bus.err_code), 32'd2);
        req(7, 1, 1, 1, 0);
        tick();
        chk("illegal code", 32'(bus.err_code), 32'd3);
        idle();
        tick();
        chk("err pulse ends", 32'(bus.err), 32'd0);
        chk("err enc_cnt",    32'(bus.enc_cnt), 32'd5);

        // clear together with a request
        bus.out_ready = 1'b0;
        req(3, 1, 2, 3, 0);
        tick();
        req(3, 4, 5, 6, 0);
        tick();
        bus.clear = 1'b1;
        req(3, 7, 8, 9, 0);
        tick();
        chk("clear empty",    32'(bus.out_valid), 32'd0);
        chk("clear addr",     bus.out_addr, 32'h0);
        chk("clear enc_cnt",  32'(bus.enc_cnt), 32'd0);
        chk("clear keeps code", 32'(bus.err_code), 32'd3);
        idle();
        tick();
        chk("clear dropped req", 32'(bus.out_valid), 32'd0);

        // randomized traffic with one mid-run reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int op, imm;
            op  = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) imm = int'($signed(13'($urandom)));
            else imm = int'($signed(12'($urandom))) & ~32'sd1;
            if ($urandom_range(0, 3) != 0) req(op, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
            else bus.in_valid = 1'b0;
            bus.out_ready = (cyc % 400 < 100) ? ($urandom_range(0, 4) == 0)
                                              : ($urandom_range(0, 2) != 0);
            bus.clear = ($urandom_range(0, 99) == 0);
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                tick();
                #2 rst_n = 1'b1;
            end
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
